// File: rtl/pipe_ctrl_if.sv
// Decode/EX control bundle between the IF/ID register, the control unit and the EX datapath.
interface pipe_ctrl_if #(
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned ALUCTR_W = 5
);
  logic                id_valid;
  logic [5:0]          op;
  logic [5:0]          func;
  logic [RADDR_W-1:0]  rs;
  logic [RADDR_W-1:0]  rt;
  logic [RADDR_W-1:0]  rd;
  logic                ex_taken;
  logic                stall;
  logic                flush_id;
  logic                ex_valid;
  logic                ex_regwr;
  logic                ex_memwr;
  logic                ex_mem2reg;
  logic                ex_alusrc;
  logic                ex_extop;
  logic                ex_link;
  logic [RADDR_W-1:0]  ex_dst;
  logic [ALUCTR_W-1:0] ex_aluctr;
  logic                ex_mdu_start;
  logic                mdu_busy;

  modport master (
    output id_valid, op, func, rs, rt, rd, ex_taken,
    input  stall, flush_id, ex_valid, ex_regwr, ex_memwr, ex_mem2reg, ex_alusrc,
           ex_extop, ex_link, ex_dst, ex_aluctr, ex_mdu_start, mdu_busy
  );

  modport slave (
    input  id_valid, op, func, rs, rt, rd, ex_taken,
    output stall, flush_id, ex_valid, ex_regwr, ex_memwr, ex_mem2reg, ex_alusrc,
           ex_extop, ex_link, ex_dst, ex_aluctr, ex_mdu_start, mdu_busy
  );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Decode-stage control: op/func decode into ID/EX, load-use and MDU stall detection,
// branch flush, and the MDU occupancy counter.
module pipe_ctrl_unit #(
  parameter int unsigned ALUCTR_W = 5,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned MDU_LAT  = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MDU_LAT);

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J     = 6'b000010,
                         OP_JAL   = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE   = 6'b000101,
                         OP_BLEZ  = 6'b000110, OP_BGTZ   = 6'b000111, OP_ADDIU = 6'b001001,
                         OP_SLTI  = 6'b001010, OP_SLTIU  = 6'b001011, OP_ANDI  = 6'b001100,
                         OP_ORI   = 6'b001101, OP_XORI   = 6'b001110, OP_LUI   = 6'b001111,
                         OP_LB    = 6'b100000, OP_LW     = 6'b100011, OP_LBU   = 6'b100100,
                         OP_SB    = 6'b101000, OP_SW     = 6'b101011;

  localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011,
                         F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111,
                         F_JR   = 6'b001000, F_JALR = 6'b001001, F_MFHI = 6'b010000,
                         F_MFLO = 6'b010010, F_ADDU = 6'b100001, F_SUBU = 6'b100011,
                         F_AND  = 6'b100100, F_OR   = 6'b100101, F_XOR  = 6'b100110,
                         F_NOR  = 6'b100111, F_SLT  = 6'b101010, F_SLTU = 6'b101011;

  typedef struct packed {
    logic                regwr;
    logic                memwr;
    logic                mem2reg;
    logic                alusrc;
    logic                extop;
    logic                link;
    logic [RADDR_W-1:0]  dst;
    logic [ALUCTR_W-1:0] aluctr;
  } ctrl_t;

  ctrl_t            dec, ex_q;
  logic             ex_valid_q, mdu_start_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rtype, is_mdu, is_hilo, uses_rs, uses_rt;
  logic             load_use_c, mdu_haz_c, stall_c, load_ex_c;

  // Combinational decode of the instruction sitting in IF/ID.
  always_comb begin
    dec     = '0;
    rtype   = (bus.op == OP_RTYPE);
    is_mdu  = rtype && (bus.func[5:2] == 4'b0110);
    is_hilo = rtype && ((bus.func == F_MFHI) || (bus.func == F_MFLO));
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    if (rtype) begin
      dec.regwr = (bus.func != F_JR) && !is_mdu;
      dec.link  = (bus.func == F_JALR);
      dec.dst   = bus.rd;
      uses_rt   = 1'b1;
      case (bus.func)
        F_ADDU: dec.aluctr = ALUCTR_W'(0);
        F_SUBU: dec.aluctr = ALUCTR_W'(1);
        F_SLT:  dec.aluctr = ALUCTR_W'(2);
        F_AND:  dec.aluctr = ALUCTR_W'(3);
        F_NOR:  dec.aluctr = ALUCTR_W'(4);
        F_OR:   dec.aluctr = ALUCTR_W'(5);
        F_XOR:  dec.aluctr = ALUCTR_W'(6);
        F_SLL:  begin dec.aluctr = ALUCTR_W'(7);  uses_rs = 1'b0; end
        F_SRL:  begin dec.aluctr = ALUCTR_W'(8);  uses_rs = 1'b0; end
        F_SLTU: dec.aluctr = ALUCTR_W'(9);
        F_JALR: dec.aluctr = ALUCTR_W'(10);
        F_JR:   dec.aluctr = ALUCTR_W'(11);
        F_SLLV: dec.aluctr = ALUCTR_W'(12);
        F_SRA:  begin dec.aluctr = ALUCTR_W'(13); uses_rs = 1'b0; end
        F_SRAV: dec.aluctr = ALUCTR_W'(14);
        F_SRLV: dec.aluctr = ALUCTR_W'(15);
        default: dec.aluctr = '0;
      endcase
    end else begin
      dec.dst = bus.rt;
      case (bus.op)
        OP_J:   uses_rs = 1'b0;
        OP_JAL: begin
          dec.regwr = 1'b1; dec.link = 1'b1; dec.aluctr = ALUCTR_W'(10);
          dec.dst = RADDR_W'(31); uses_rs = 1'b0;
        end
        OP_BEQ, OP_BNE: begin dec.aluctr = ALUCTR_W'(1); uses_rt = 1'b1; end
        OP_BLEZ, OP_BGTZ, OP_REGIMM: dec.aluctr = ALUCTR_W'(1);
        OP_ADDIU: begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; end
        OP_SLTI: begin
          dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.aluctr = ALUCTR_W'(2);
        end
        OP_SLTIU: begin
          dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; dec.aluctr = ALUCTR_W'(9);
        end
        OP_ANDI: begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluctr = ALUCTR_W'(3); end
        OP_ORI:  begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluctr = ALUCTR_W'(5); end
        OP_XORI: begin dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluctr = ALUCTR_W'(6); end
        OP_LUI: begin
          dec.regwr = 1'b1; dec.alusrc = 1'b1; dec.aluctr = ALUCTR_W'(16); uses_rs = 1'b0;
        end
        OP_LW, OP_LB, OP_LBU: begin
          dec.regwr = 1'b1; dec.mem2reg = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1;
        end
        OP_SW, OP_SB: begin
          dec.memwr = 1'b1; dec.alusrc = 1'b1; dec.extop = 1'b1; uses_rt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A flush outranks a stall; the killed ID instruction cannot be hazarded.
  assign load_use_c = ex_valid_q && ex_q.mem2reg && (ex_q.dst != '0) &&
                      ((uses_rs && (bus.rs == ex_q.dst)) || (uses_rt && (bus.rt == ex_q.dst)));
  assign mdu_haz_c  = (cnt_q != '0) && (is_mdu || is_hilo);
  assign stall_c    = bus.id_valid && !bus.ex_taken && (load_use_c || mdu_haz_c);
  assign load_ex_c  = bus.id_valid && !bus.ex_taken && !stall_c;

  // ID/EX register and MDU occupancy counter; reset aborts any MDU operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      ex_valid_q  <= 1'b0;
      mdu_start_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= load_ex_c;
      ex_q        <= load_ex_c ? dec : '0;
      mdu_start_q <= load_ex_c && is_mdu;
      if (load_ex_c && is_mdu) cnt_q <= CNT_W'(MDU_LAT - 1);
      else if (cnt_q != '0)    cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bus.stall        = stall_c;
  assign bus.flush_id     = bus.ex_taken;
  assign bus.ex_valid     = ex_valid_q;
  assign bus.ex_regwr     = ex_q.regwr;
  assign bus.ex_memwr     = ex_q.memwr;
  assign bus.ex_mem2reg   = ex_q.mem2reg;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_extop     = ex_q.extop;
  assign bus.ex_link      = ex_q.link;
  assign bus.ex_dst       = ex_q.dst;
  assign bus.ex_aluctr    = ex_q.aluctr;
  assign bus.ex_mdu_start = mdu_start_q;
  assign bus.mdu_busy     = (cnt_q != '0);
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: hazards, flushes, MDU sequencing, decode and async reset.
module tb_pipe_ctrl_unit;
  localparam int unsigned RADDR_W  = 5;
  localparam int unsigned ALUCTR_W = 5;

  localparam logic [5:0] OP_R = 6'b000000, OP_JAL = 6'b000011, OP_ADDIU = 6'b001001,
                         OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] F_ADDU = 6'b100001, F_JR = 6'b001000, F_MULT = 6'b011000,
                         F_MFLO = 6'b010010;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  pipe_ctrl_if #(.RADDR_W(RADDR_W), .ALUCTR_W(ALUCTR_W)) bus ();

  pipe_ctrl_unit #(.ALUCTR_W(ALUCTR_W), .RADDR_W(RADDR_W), .MDU_LAT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                       input int s, input int t, input int d);
    bus.id_valid = v;
    bus.op       = o;
    bus.func     = f;
    bus.rs       = RADDR_W'(s);
    bus.rt       = RADDR_W'(t);
    bus.rd       = RADDR_W'(d);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.ex_taken = 1'b0;
    drive(1'b0, OP_R, 6'd0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", 32'(bus.ex_valid), 0);
    check("rst_mdu_busy", 32'(bus.mdu_busy), 0);
    check("rst_regwr",    32'(bus.ex_regwr), 0);
    rst_n = 1'b1;

    // lw $2,0($1) then addu $3,$2,$4: one stall, bubble, then addu issues
    drive(1'b1, OP_LW, 6'd0, 1, 2, 0);
    check("lw_stall", 32'(bus.stall), 0);
    tick();
    check("lw_valid",   32'(bus.ex_valid),   1);
    check("lw_mem2reg", 32'(bus.ex_mem2reg), 1);
    check("lw_dst",     32'(bus.ex_dst),     2);
    check("lw_ctl",     32'({bus.ex_regwr, bus.ex_alusrc, bus.ex_extop, bus.ex_memwr}), 32'b1110);
    drive(1'b1, OP_R, F_ADDU, 2, 4, 3);
    check("lu_stall", 32'(bus.stall), 1);
    tick();
    check("lu_bubble_valid", 32'(bus.ex_valid), 0);
    check("lu_bubble_regwr", 32'(bus.ex_regwr), 0);
    check("lu_stall_clear",  32'(bus.stall),    0);
    tick();
    check("addu_valid", 32'(bus.ex_valid), 1);
    check("addu_dst",   32'(bus.ex_dst),   3);
    check("addu_ctl",   32'({bus.ex_regwr, bus.ex_alusrc, bus.ex_mem2reg}), 32'b100);

    // lw $0 then use of $0: no hazard
    drive(1'b1, OP_LW, 6'd0, 1, 0, 0);
    tick();
    drive(1'b1, OP_R, F_ADDU, 0, 4, 3);
    check("r0_stall", 32'(bus.stall), 0);
    // lw $2 then lui $2: lui reads no register
    drive(1'b1, OP_LW, 6'd0, 1, 2, 0);
    tick();
    drive(1'b1, OP_LUI, 6'd0, 2, 2, 0);
    check("lui_stall", 32'(bus.stall), 0);
    tick();
    check("lui_aluctr", 32'(bus.ex_aluctr), 16);
    check("lui_dst",    32'(bus.ex_dst),    2);
    check("lui_regwr",  32'(bus.ex_regwr),  1);

    // lw $2 then sw $2,0($1): store data operand hazard through rt
    drive(1'b1, OP_LW, 6'd0, 1, 2, 0);
    tick();
    drive(1'b1, OP_SW, 6'd0, 1, 2, 0);
    check("sw_stall", 32'(bus.stall), 1);
    tick();
    tick();
    check("sw_memwr", 32'(bus.ex_memwr), 1);
    check("sw_regwr", 32'(bus.ex_regwr), 0);

    // Taken branch while ID has a load-use hazard: flush wins
    drive(1'b1, OP_LW, 6'd0, 1, 2, 0);
    tick();
    bus.ex_taken = 1'b1;
    drive(1'b1, OP_R, F_ADDU, 2, 4, 3);
    check("flush_id",    32'(bus.flush_id), 1);
    check("flush_stall", 32'(bus.stall),    0);
    tick();
    bus.ex_taken = 1'b0;
    check("flush_bubble", 32'(bus.ex_valid), 0);

    // Invalid ID slot produces a bubble
    drive(1'b0, OP_ADDIU, 6'd0, 1, 7, 0);
    tick();
    check("idle_bubble", 32'(bus.ex_valid), 0);

    // mult then mflo with MDU_LAT=4
    drive(1'b1, OP_R, F_MULT, 2, 3, 0);
    tick();
    check("mult_start", 32'(bus.ex_mdu_start), 1);
    check("mult_regwr", 32'(bus.ex_regwr),     0);
    drive(1'b1, OP_R, F_MFLO, 0, 0, 5);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mdu_busy%0d", i),  32'(bus.mdu_busy), 1);
      check($sformatf("mdu_stall%0d", i), 32'(bus.stall),    1);
      if (i == 1) check("mdu_start_pulse", 32'(bus.ex_mdu_start), 0);
      tick();
    end
    check("mdu_idle",       32'(bus.mdu_busy), 0);
    check("mdu_stall_done", 32'(bus.stall),    0);
    tick();
    check("mflo_valid", 32'(bus.ex_valid), 1);
    check("mflo_regwr", 32'(bus.ex_regwr), 1);
    check("mflo_dst",   32'(bus.ex_dst),   5);

    // jal then jr $31
    drive(1'b1, OP_JAL, 6'd0, 0, 0, 0);
    tick();
    check("jal_dst",    32'(bus.ex_dst),    31);
    check("jal_link",   32'(bus.ex_link),   1);
    check("jal_regwr",  32'(bus.ex_regwr),  1);
    check("jal_aluctr", 32'(bus.ex_aluctr), 10);
    drive(1'b1, OP_R, F_JR, 31, 0, 0);
    tick();
    check("jr_regwr",  32'(bus.ex_regwr),  0);
    check("jr_aluctr", 32'(bus.ex_aluctr), 11);
    check("jr_valid",  32'(bus.ex_valid),  1);

    // Async reset mid-MDU with a live addiu in EX
    drive(1'b1, OP_R, F_MULT, 2, 3, 0);
    tick();
    drive(1'b1, OP_ADDIU, 6'd0, 1, 7, 0);
    tick();
    check("pre_rst_busy",  32'(bus.mdu_busy), 1);
    check("pre_rst_regwr", 32'(bus.ex_regwr), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",  32'(bus.mdu_busy), 0);
    check("arst_valid", 32'(bus.ex_valid), 0);
    check("arst_ctl",   32'({bus.ex_regwr, bus.ex_alusrc, bus.ex_extop, bus.ex_mdu_start}), 0);
    check("arst_dst",   32'(bus.ex_dst),   0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
